retro_catc_multi: RTL

RETRO_CATC_MULTI -- requirements
Module: retro_catc_multi

---
 rtl/retro_catc_pkg.sv | 20 ++
 rtl/retro_catc_channel.sv | 92 +++++++++
 rtl/retro_catc_multi.sv | 48 ++++
 3 files changed

// File: rtl/retro_catc_pkg.sv
// Shared widths, typedefs and increment helper for the multi-channel catch-up clock-enable.
// Optional build macro: RETRO_CATC_LOCKSTEP_EN (selects lockstep stalling in retro_catc_multi).
package retro_catc_pkg;

    localparam int DefChannels   = 2;
    localparam int DefPhaseWidth = 32;
    localparam int DefOwedWidth  = 16;
    localparam int DefBoostShift = 1;

    typedef logic [DefPhaseWidth-1:0] phaseT;
    typedef logic [DefOwedWidth-1:0]  owedT;

    // Inc = refHz / coreHz * 2^DefPhaseWidth, for elaboration-time constants.
    function automatic phaseT calcInc(input longint unsigned refHz, input longint unsigned coreHz);
        longint unsigned scaled;
        scaled = (refHz << DefPhaseWidth) / coreHz;
        return phaseT'(scaled);
    endfunction

endpackage

// File: rtl/retro_catc_channel.sv
// One catch-up clock-enable channel: nominal phase accumulator, owed-tick counter and
// boosted catch-up accumulator that repays ticks lost while stalled.
module retro_catc_channel
    import retro_catc_pkg::*;
#(
    parameter int PhaseWidth = DefPhaseWidth,
    parameter int OwedWidth  = DefOwedWidth,
    parameter int BoostShift = DefBoostShift
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  ClkEn,
    input  logic [PhaseWidth-1:0] Inc,
    input  logic                  Stall,
    input  logic                  ClearStatus,
    output logic                  ClkEnOut,
    output logic                  Behind,
    output logic                  Saturated
);

    localparam int SumWidth = PhaseWidth + BoostShift + 1;
    localparam logic [OwedWidth-1:0] OwedOne = OwedWidth'(1);

    logic [PhaseWidth-1:0] nomAcc;
    logic [PhaseWidth-1:0] outAcc;
    logic [PhaseWidth-1:0] outAccNext;
    logic [OwedWidth-1:0]  owed;
    logic [OwedWidth-1:0]  owedNext;
    logic [PhaseWidth:0]   nomSum;
    logic [SumWidth-1:0]   boost;
    logic [SumWidth-1:0]   boostSum;
    logic                  nomTick;
    logic                  boostCarry;
    logic                  tick;
    logic                  clip;

    always_comb begin
        nomSum     = {1'b0, nomAcc} + {1'b0, Inc};
        nomTick    = nomSum[PhaseWidth];
        boost      = {{(BoostShift + 1){1'b0}}, Inc} << BoostShift;
        boostSum   = {{(BoostShift + 1){1'b0}}, outAcc} + boost;
        // Any bit at or above 2^PhaseWidth is a carry, so a boost >= 2^PhaseWidth ticks every cycle.
        boostCarry = |boostSum[SumWidth-1:PhaseWidth];
        tick       = 1'b0;
        outAccNext = outAcc;
        owedNext   = owed;
        clip       = 1'b0;

        if (owed == '0) begin
            tick       = nomTick & ~Stall;
            outAccNext = '0;
        end else if (!Stall) begin
            tick       = boostCarry;
            outAccNext = boostSum[PhaseWidth-1:0];
        end

        if (nomTick && !tick) begin
            if (owed == '1) clip = 1'b1;
            else            owedNext = owed + OwedOne;
        end else if (!nomTick && tick) begin
            owedNext = owed - OwedOne;
        end

        if (owedNext == '0) outAccNext = '0;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            nomAcc    <= '0;
            outAcc    <= '0;
            owed      <= '0;
            ClkEnOut  <= 1'b0;
            Behind    <= 1'b0;
            Saturated <= 1'b0;
        end else begin
            if (ClkEn) begin
                nomAcc   <= nomSum[PhaseWidth-1:0];
                outAcc   <= outAccNext;
                owed     <= owedNext;
                ClkEnOut <= tick;
                Behind   <= (owedNext != '0);
            end else begin
                ClkEnOut <= 1'b0;
                Behind   <= (owed != '0);
            end
            // A clip in the same cycle as ClearStatus keeps the flag set.
            if (ClkEn && clip)    Saturated <= 1'b1;
            else if (ClearStatus) Saturated <= 1'b0;
        end
    end

endmodule

// File: rtl/retro_catc_multi.sv
// Multi-channel catch-up clock-enable generator: one retro_catc_channel per channel.
// Build macro RETRO_CATC_LOCKSTEP_EN makes every channel stall on the OR of all Delay bits.
module retro_catc_multi
    import retro_catc_pkg::*;
#(
    parameter int Channels   = DefChannels,
    parameter int PhaseWidth = DefPhaseWidth,
    parameter int OwedWidth  = DefOwedWidth,
    parameter int BoostShift = DefBoostShift
) (
    input  logic                                Clk,
    input  logic                                Reset_n,
    input  logic                                ClkEn,
    input  logic [Channels-1:0][PhaseWidth-1:0] Inc,
    input  logic [Channels-1:0]                 Delay,
    input  logic                                ClearStatus,
    output logic [Channels-1:0]                 ClkEnOut,
    output logic [Channels-1:0]                 Behind,
    output logic [Channels-1:0]                 Saturated
);

    logic [Channels-1:0] stall;

`ifdef RETRO_CATC_LOCKSTEP_EN
    assign stall = {Channels{|Delay}};
`else
    assign stall = Delay;
`endif

    for (genvar c = 0; c < Channels; c++) begin : gChannel
        retro_catc_channel #(
            .PhaseWidth (PhaseWidth),
            .OwedWidth  (OwedWidth),
            .BoostShift (BoostShift)
        ) uChannel (
            .Clk         (Clk),
            .Reset_n     (Reset_n),
            .ClkEn       (ClkEn),
            .Inc         (Inc[c]),
            .Stall       (stall[c]),
            .ClearStatus (ClearStatus),
            .ClkEnOut    (ClkEnOut[c]),
            .Behind      (Behind[c]),
            .Saturated   (Saturated[c])
        );
    end

endmodule
